alu_trace_recorder: RTL and testbench

ALU_TRACE_RECORDER -- requirements
Module: alu_trace_recorder

---
 rtl/alu_trace_if.sv | 32 +++
 rtl/alu_trace_recorder.sv | 110 +++++++++++
 tb/tb_alu_trace_recorder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/alu_trace_if.sv
// Bundle of the ALU observation, control and trace read-back signals.
// master drives the ALU and control signals; slave is the recorder.
interface alu_trace_if #(parameter int MEMWIDTH = 32);
    logic [7:0]          a;
    logic [7:0]          b;
    logic [1:0]          ALU_sel;
    logic [1:0]          load_shift;
    logic                cout;
    logic                zout;
    logic [7:0]          result;
    logic                cap_valid;
    logic                arm;
    logic                stop;
    logic                rd_req;
    logic [MEMWIDTH-1:0] rd_data;
    logic                rd_valid;
    logic [4:0]          count;
    logic                full;
    logic [1:0]          state;

    modport master (
        output a, b, ALU_sel, load_shift, cout, zout, result,
               cap_valid, arm, stop, rd_req,
        input  rd_data, rd_valid, count, full, state
    );

    modport slave (
        input  a, b, ALU_sel, load_shift, cout, zout, result,
               cap_valid, arm, stop, rd_req,
        output rd_data, rd_valid, count, full, state
    );
endinterface

// File: rtl/alu_trace_recorder.sv
// Records packed ALU operations into a 16-entry trace buffer and dumps them in
// write order. Define TRACE_WRAP_EN to keep recording past full (ring overwrite).
module alu_trace_recorder #(
    parameter int MEMWIDTH = 32,
    parameter int DEPTH    = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_trace_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RECORD = 2'b01,
        HOLD   = 2'b10,
        DUMP   = 2'b11
    } state_t;

    state_t              st, st_nxt;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       cnt;
    logic [MEMWIDTH-1:0] mem [DEPTH];
    logic [MEMWIDTH-1:0] rd_word;
    logic                rd_v;
    logic                do_wr, do_rd, do_arm;
    logic [31:0]         trace_word;

    // Same layout as the ALU test-vector file so a dump reloads directly.
    assign trace_word = {bus.a, bus.b, bus.ALU_sel, bus.load_shift, 2'b00,
                         bus.zout, bus.cout, bus.result};

    always_comb begin
        st_nxt = st;
        do_wr  = 1'b0;
        do_rd  = 1'b0;
        do_arm = 1'b0;
        unique case (st)
            IDLE: begin
                if (bus.arm) begin
                    do_arm = 1'b1;
                    st_nxt = RECORD;
                end
            end
            RECORD: begin
`ifdef TRACE_WRAP_EN
                do_wr = bus.cap_valid;
                if (bus.stop) st_nxt = HOLD;
`else
                do_wr = bus.cap_valid && (cnt != CNT_FULL);
                if (bus.stop || (do_wr && cnt == CNT_FULL - CNT_ONE)) st_nxt = HOLD;
`endif
            end
            HOLD, DUMP: begin
                if (bus.rd_req) begin
                    if (cnt != '0) begin
                        do_rd  = 1'b1;
                        st_nxt = (cnt == CNT_ONE) ? IDLE : DUMP;
                    end else if (st == HOLD) begin
                        st_nxt = IDLE;
                    end
                end
            end
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st      <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            rd_v    <= 1'b0;
            rd_word <= '0;
        end else begin
            st   <= st_nxt;
            rd_v <= do_rd;
            if (do_arm) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
                // Only reachable with wrap enabled: drop the oldest entry.
                if (cnt == CNT_FULL) rd_ptr <= rd_ptr + AW'(1);
                else                 cnt    <= cnt + CNT_ONE;
            end
            if (do_rd) begin
                rd_word <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
                cnt     <= cnt - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_wr) mem[wr_ptr] <= MEMWIDTH'(trace_word);
    end

    assign bus.rd_data  = rd_word;
    assign bus.rd_valid = rd_v;
    assign bus.count    = 5'(cnt);
    assign bus.full     = (cnt == CNT_FULL);
    assign bus.state    = st;
endmodule

// File: tb/tb_alu_trace_recorder.sv
// Directed and random checks of alu_trace_recorder against a queue-based trace model.
module tb_alu_trace_recorder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_trace_if #(.MEMWIDTH(32)) bus ();
    alu_trace_recorder #(.MEMWIDTH(32), .DEPTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad = 0;

    // Model: mode 0 idle, 1 recording, 2 holding, 3 dumping; queue = unread trace.
    int          m_mode = 0;
    logic [31:0] m_q[$];
    logic        m_rdv = 1'b0;
    logic [31:0] m_rdd = 32'h0;

    function automatic logic [31:0] pack_op();
        return (32'(bus.a) << 24) + (32'(bus.b) << 16) + (32'(bus.ALU_sel) << 14) +
               (32'(bus.load_shift) << 12) + (32'(bus.zout) << 9) + (32'(bus.cout) << 8) +
               32'(bus.result);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [31:0] w);
        if (!rst_n) begin
            m_mode = 0; m_q.delete(); m_rdv = 1'b0; m_rdd = 32'h0;
            return;
        end
        m_rdv = 1'b0;
        case (m_mode)
            0: if (bus.arm) begin m_q.delete(); m_mode = 1; end
            1: begin
                if (bus.cap_valid) begin
`ifdef TRACE_WRAP_EN
                    if (m_q.size() == 16) void'(m_q.pop_front());
                    m_q.push_back(w);
`else
                    m_q.push_back(w);
                    if (m_q.size() == 16) m_mode = 2;
`endif
                end
                if (bus.stop) m_mode = 2;
            end
            default: if (bus.rd_req) begin
                if (m_q.size() > 0) begin
                    m_rdd = m_q.pop_front();
                    m_rdv = 1'b1;
                    m_mode = (m_q.size() == 0) ? 0 : 3;
                end else if (m_mode == 2) m_mode = 0;
            end
        endcase
    endtask

    task automatic cyc();
        logic [31:0] w;
        w = pack_op();
        @(posedge clk);
        model_edge(w);
        #1;
        chk("state", 32'(bus.state), 32'(m_mode));
        chk("count", 32'(bus.count), 32'(m_q.size()));
        chk("full", 32'(bus.full), 32'(m_q.size() == 16));
        chk("rd_valid", 32'(bus.rd_valid), 32'(m_rdv));
        chk("rd_data", bus.rd_data, m_rdd);
    endtask

    task automatic set_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel,
                          input logic [1:0] sh, input logic [7:0] r, input logic c, input logic z);
        bus.a = a; bus.b = b; bus.ALU_sel = sel; bus.load_shift = sh;
        bus.result = r; bus.cout = c; bus.zout = z;
    endtask

    task automatic set_ctl(input logic cv, input logic ar, input logic st, input logic rq);
        bus.cap_valid = cv; bus.arm = ar; bus.stop = st; bus.rd_req = rq;
    endtask

    initial begin
        logic [7:0] top;
        int base;
        set_op(8'h0, 8'h0, 2'd0, 2'd0, 8'h0, 1'b0, 1'b0);
        set_ctl(1'b1, 1'b1, 1'b1, 1'b1);

        // reset with every control input asserted
        rst_n = 1'b0;
        cyc(); cyc();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_rdv", 32'(bus.rd_valid), 32'd0);
        chk("rst_rdd", bus.rd_data, 32'h0);

        // three captures, stop, three reads
        rst_n = 1'b1;
        set_ctl(1'b0, 1'b1, 1'b0, 1'b0); cyc();
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        set_op(8'h01, 8'h02, 2'd0, 2'd0, 8'h03, 1'b0, 1'b0); cyc();
        set_op(8'hFF, 8'h01, 2'd0, 2'd0, 8'h00, 1'b1, 1'b1); cyc();
        // the third vector's word is 0FF01200: load_shift field = 1
        set_op(8'h0F, 8'hF0, 2'd0, 2'd1, 8'h00, 1'b0, 1'b1); cyc();
        chk("cnt3", 32'(bus.count), 32'd3);
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0); cyc();
        chk("hold", 32'(bus.state), 32'd2);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(); chk("v0", bus.rd_data, 32'h01020003); chk("v0_vld", 32'(bus.rd_valid), 32'd1);
        cyc(); chk("v1", bus.rd_data, 32'hFF010300);
        cyc(); chk("v2", bus.rd_data, 32'h0FF01200); chk("v_idle", 32'(bus.state), 32'd0);
        cyc(); chk("v_novld", 32'(bus.rd_valid), 32'd0); chk("v_hold", bus.rd_data, 32'h0FF01200);

        // 20 consecutive captures
        set_ctl(1'b0, 1'b1, 1'b0, 1'b0); cyc();
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            set_op(8'(i), 8'(i + 100), 2'(i), 2'(i >> 2), 8'(i * 3), 1'(i), 1'(i >> 1));
            cyc();
`ifndef TRACE_WRAP_EN
            if (i == 15) begin
                chk("nw_full", 32'(bus.full), 32'd1);
                chk("nw_hold", 32'(bus.state), 32'd2);
            end
`endif
        end
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0); cyc();
        chk("cnt16", 32'(bus.count), 32'd16);
`ifdef TRACE_WRAP_EN
        base = 4;
`else
        base = 0;
`endif
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cyc();
            top = bus.rd_data[31:24];
            chk("dump_a", 32'(top), 32'(base + i));
        end
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0); cyc();
        chk("dump_idle", 32'(bus.state), 32'd0);

        // reset in the middle of a dump
        set_ctl(1'b0, 1'b1, 1'b0, 1'b0); cyc();
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            set_op(8'(8'h40 + i), 8'h11, 2'd1, 2'd2, 8'h22, 1'b0, 1'b0); cyc();
        end
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0); cyc();
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1); cyc(); cyc();
        chk("mid_cnt", 32'(bus.count), 32'd2);
        rst_n = 1'b0; cyc();
        chk("mr_state", 32'(bus.state), 32'd0);
        chk("mr_count", 32'(bus.count), 32'd0);
        chk("mr_rdv", 32'(bus.rd_valid), 32'd0);
        rst_n = 1'b1; cyc(); cyc();
        chk("mr_norr", 32'(bus.rd_valid), 32'd0);

        // capture and stop together, then arm outside idle
        set_ctl(1'b0, 1'b1, 1'b0, 1'b0); cyc();
        set_ctl(1'b1, 1'b1, 1'b1, 1'b0);
        set_op(8'hAA, 8'h55, 2'd2, 2'd3, 8'h0F, 1'b1, 1'b0); cyc();
        chk("cs_cnt", 32'(bus.count), 32'd1);
        chk("cs_hold", 32'(bus.state), 32'd2);
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0); cyc(); cyc();
        chk("arm_hold_cnt", 32'(bus.count), 32'd1);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1); cyc();
        top = bus.rd_data[31:24];
        chk("cs_a", 32'(top), 32'hAA);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            set_ctl(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
            set_op(8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom), 8'($urandom),
                   1'($urandom), 1'($urandom));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
